// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, one report per press.
//   clk            : system clock
//   rst            : synchronous reset, active-low
//   row_i[3:0]     : row sense lines, active-low, asynchronous to clk
//   col_o[3:0]     : column drive, active-low one-hot
//   dato_listo_o   : one-clock pulse per debounced press
//   dato_codc_o    : column index of last reported key (held)
//   dato_codf_o    : row index of last reported key (held)
//   tecla_activa_o : high from report until release is debounced
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 27000,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       dato_listo_o,
  output logic [1:0] dato_codc_o,
  output logic [1:0] dato_codf_o,
  output logic       tecla_activa_o
);

  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_WAIT_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        col_q, col_d;
  logic              listo_q, listo_d;
  logic [1:0]        codc_q, codc_d;
  logic [1:0]        codf_q, codf_d;
  logic              tecla_q, tecla_d;
  logic [3:0]        row_meta_q, row_meta_d;
  logic [3:0]        row_s_q, row_s_d;
  logic [1:0]        next_col;

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-numbered row that reads low; ties between rows resolve to the smaller index.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    col_d      = col_q;
    listo_d    = 1'b0;
    codc_d     = codc_q;
    codf_d     = codf_q;
    tecla_d    = tecla_q;
    row_meta_d = row_i;
    row_s_d    = row_meta_q;
    next_col   = col_idx_q + 2'd1;

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (row_s_q == 4'b1111) begin
            col_idx_d = next_col;
            col_d     = col_drive(next_col);
          end else begin
            row_idx_d = lowest_low(row_s_q);
            deb_cnt_d = '0;
            state_d   = ST_DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (row_s_q[row_idx_q]) begin
          // Bounce: give up on this column and keep scanning.
          state_d    = ST_SCAN;
          scan_cnt_d = '0;
          col_idx_d  = next_col;
          col_d      = col_drive(next_col);
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = ST_REPORT;
          deb_cnt_d = '0;
          listo_d   = 1'b1;
          codc_d    = col_idx_q;
          codf_d    = row_idx_q;
          tecla_d   = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      ST_REPORT: begin
        state_d   = ST_WAIT_RELEASE;
        deb_cnt_d = '0;
      end

      ST_WAIT_RELEASE: begin
        // Any low row on the held column restarts the release window.
        if (row_s_q != 4'b1111) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = ST_SCAN;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          tecla_d    = 1'b0;
          col_idx_d  = next_col;
          col_d      = col_drive(next_col);
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_SCAN;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      listo_q    <= 1'b0;
      codc_q     <= 2'd0;
      codf_q     <= 2'd0;
      tecla_q    <= 1'b0;
      row_meta_q <= 4'b1111;
      row_s_q    <= 4'b1111;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      col_q      <= col_d;
      listo_q    <= listo_d;
      codc_q     <= codc_d;
      codf_q     <= codf_d;
      tecla_q    <= tecla_d;
      row_meta_q <= row_meta_d;
      row_s_q    <= row_s_d;
    end
  end

  assign col_o          = col_q;
  assign dato_listo_o   = listo_q;
  assign dato_codc_o    = codc_q;
  assign dato_codf_o    = codf_q;
  assign tecla_activa_o = tecla_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad and a report scoreboard.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int unsigned SCAN_CYCLES     = 4;
  localparam int unsigned DEBOUNCE_CYCLES = 8;

  typedef struct packed {
    logic [1:0] c;
    logic [1:0] r;
  } rep_t;

  logic       clk;
  logic       rst;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic       dato_listo_o;
  logic [1:0] dato_codc_o;
  logic [1:0] dato_codf_o;
  logic       tecla_activa_o;

  logic [3:0][3:0] keys;   // keys[col][row] pressed
  rep_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   pulse_cnt;
  bit   mon_en;

  keypad_scanner #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .row_i         (row_i),
    .col_o         (col_o),
    .dato_listo_o  (dato_listo_o),
    .dato_codc_o   (dato_codc_o),
    .dato_codf_o   (dato_codf_o),
    .tecla_activa_o(tecla_activa_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its row low while its column is driven low.
  always_comb begin
    row_i = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (col_o[c] === 1'b0) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c][r]) row_i[r] = 1'b0;
        end
      end
    end
  end

  // Report monitor: every pulse must match the oldest expected report.
  always @(negedge clk) begin
    if (mon_en && dato_listo_o === 1'b1) begin
      rep_t e;
      pulse_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got codc=%0d codf=%0d, expected no pulse", dato_codc_o, dato_codf_o);
      end else begin
        e = exp_q.pop_front();
        if ({dato_codc_o, dato_codf_o} !== {e.c, e.r}) begin
          n_fail++;
          $display("FAIL report_code: got codc=%0d codf=%0d, expected codc=%0d codf=%0d",
                   dato_codc_o, dato_codf_o, e.c, e.r);
        end
      end
      n_checks++;
      if (tecla_activa_o !== 1'b1) begin
        n_fail++;
        $display("FAIL tecla_on_report: got %b, expected 1", tecla_activa_o);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns at the first negedge where column idx has just become driven.
  task automatic wait_col_enter(input int idx, output bit ok);
    logic [3:0] tgt, prev;
    tgt  = ~(4'b0001 << idx);
    prev = col_o;
    ok   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col_o === tgt && prev !== tgt) begin
        ok = 1'b1;
        break;
      end
      prev = col_o;
    end
  endtask

  // Counts negedges after a release until tecla_activa_o falls (0 = never).
  task automatic count_release(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (tecla_activa_o === 1'b0) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    keys   = '0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (col_o !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b, expected 1110", col_o); end
    n_checks++;
    if ({dato_listo_o, tecla_activa_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got listo=%b tecla=%b, expected 0 0", dato_listo_o, tecla_activa_o);
    end
    n_checks++;
    if ({dato_codc_o, dato_codf_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_codes: got %b, expected 0000", {dato_codc_o, dato_codf_o});
    end
    rst = 1'b1;
  endtask

  // Called right after rst is released at a negedge; checks nc cycles of idle scanning.
  task automatic test_idle_scan(input int nc, input string tag);
    logic [3:0] exp_col;
    int bad;
    bad = 0;
    for (int n = 1; n <= nc; n++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      if (col_o !== exp_col) begin
        bad++;
        if (bad == 1) $display("FAIL %s_col: cycle %0d got %b, expected %b", tag, n, col_o, exp_col);
      end
      if (dato_listo_o !== 1'b0 || tecla_activa_o !== 1'b0) begin
        bad++;
        if (bad == 1) $display("FAIL %s_flags: cycle %0d got listo=%b tecla=%b, expected 0 0",
                               tag, n, dato_listo_o, tecla_activa_o);
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
  endtask

  task automatic test_clean_press();
    rep_t e;
    int start, k;
    bit got;
    start = pulse_cnt;
    got   = 1'b0;
    e.c = 2'd3; e.r = 2'd1;
    exp_q.push_back(e);
    @(negedge clk);
    keys[3][1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dato_listo_o === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL press_timeout: got no pulse in 100 clocks, expected one"); end
    n_checks++;
    if ({tecla_activa_o, dato_listo_o, dato_codc_o, dato_codf_o} !== 6'b10_11_01) begin
      n_fail++;
      $display("FAIL press_hold: got tecla=%b listo=%b codc=%0d codf=%0d, expected 1 0 3 1",
               tecla_activa_o, dato_listo_o, dato_codc_o, dato_codf_o);
    end
    keys = '0;
    count_release(k);
    n_checks++;
    if (k != 10) begin n_fail++; $display("FAIL press_release_delay: got %0d, expected 10", k); end
    n_checks++;
    if (col_o !== 4'b1110) begin n_fail++; $display("FAIL press_resume_col: got %b, expected 1110", col_o); end
    n_checks++;
    if (pulse_cnt - start != 1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL press_pulses: got %0d pulses, expected 1", pulse_cnt - start);
    end
  endtask

  task automatic test_bounce();
    rep_t e;
    int start, k;
    bit ok, got;
    start = pulse_cnt;
    wait_col_enter(1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bounce_col_timeout: got no col1, expected col1"); end
    keys[1][2] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    keys = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (col_o !== 4'b1011) begin n_fail++; $display("FAIL bounce_resume_col: got %b, expected 1011", col_o); end
    n_checks++;
    if (pulse_cnt != start) begin n_fail++; $display("FAIL bounce_pulse: got %0d pulses, expected 0", pulse_cnt - start); end
    // Clean hold on the same key.
    e.c = 2'd1; e.r = 2'd2;
    exp_q.push_back(e);
    wait_col_enter(1, ok);
    keys[1][2] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dato_listo_o === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL bounce_clean_timeout: got no pulse, expected one"); end
    keys = '0;
    count_release(k);
    n_checks++;
    if (k != 10) begin n_fail++; $display("FAIL bounce_release_delay: got %0d, expected 10", k); end
    n_checks++;
    if (pulse_cnt - start != 1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bounce_pulses: got %0d pulses, expected 1", pulse_cnt - start);
    end
  endtask

  task automatic test_release_bounce();
    rep_t e;
    int start, k, lows;
    int dur[6];
    bit got;
    dur = '{5, 2, 6, 3, 4, 1};
    start = pulse_cnt;
    e.c = 2'd0; e.r = 2'd0;
    exp_q.push_back(e);
    @(negedge clk);
    keys[0][0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dato_listo_o === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL relb_timeout: got no pulse, expected one"); end
    // Alternate high/low with every high stretch shorter than the release window.
    lows = 0;
    for (int s = 0; s < 6; s++) begin
      keys[0][0] = (s % 2 == 1);
      for (int i = 0; i < dur[s]; i++) begin
        @(negedge clk);
        if (tecla_activa_o !== 1'b1) lows++;
      end
    end
    n_checks++;
    if (lows != 0) begin n_fail++; $display("FAIL relb_tecla_drop: got %0d low cycles, expected 0", lows); end
    keys = '0;
    count_release(k);
    n_checks++;
    if (k != 10) begin n_fail++; $display("FAIL relb_release_delay: got %0d, expected 10", k); end
    n_checks++;
    if (pulse_cnt - start != 1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL relb_pulses: got %0d pulses, expected 1", pulse_cnt - start);
    end
  endtask

  task automatic test_multi_row();
    rep_t e;
    int start, k;
    bit got;
    start = pulse_cnt;
    e.c = 2'd2; e.r = 2'd1;
    exp_q.push_back(e);
    @(negedge clk);
    keys[2][3] = 1'b1;
    keys[2][1] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dato_listo_o === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL multi_timeout: got no pulse, expected one"); end
    keys = '0;
    count_release(k);
    n_checks++;
    if (k == 0) begin n_fail++; $display("FAIL multi_release: got no release, expected release"); end
    n_checks++;
    if (pulse_cnt - start != 1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL multi_pulses: got %0d pulses, expected 1", pulse_cnt - start);
    end
  endtask

  task automatic check_after_reset(input string tag);
    n_checks++;
    if ({col_o, dato_listo_o, tecla_activa_o, dato_codc_o, dato_codf_o} !== 10'b1110_0_0_0000) begin
      n_fail++;
      $display("FAIL %s: got col=%b listo=%b tecla=%b codc=%0d codf=%0d, expected 1110 0 0 0 0",
               tag, col_o, dato_listo_o, tecla_activa_o, dato_codc_o, dato_codf_o);
    end
  endtask

  task automatic test_reset_mid();
    rep_t e;
    int start;
    bit ok, got;
    start = pulse_cnt;
    // Reset while debouncing a press on (0,2).
    wait_col_enter(0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rmid_col_timeout: got no col0, expected col0"); end
    keys[0][2] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_after_reset("rmid_debounce");
    keys = '0;
    @(negedge clk);
    rst = 1'b1;
    test_idle_scan(10, "rmid_scan1");
    n_checks++;
    if (pulse_cnt != start) begin n_fail++; $display("FAIL rmid_pulse: got %0d pulses, expected 0", pulse_cnt - start); end
    // Reset while waiting for release of (1,0).
    e.c = 2'd1; e.r = 2'd0;
    exp_q.push_back(e);
    keys[1][0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (dato_listo_o === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rmid_wr_timeout: got no pulse, expected one"); end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_after_reset("rmid_wait_release");
    keys = '0;
    @(negedge clk);
    rst = 1'b1;
    test_idle_scan(10, "rmid_scan2");
    n_checks++;
    if (pulse_cnt - start != 1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rmid_pulses: got %0d pulses, expected 1", pulse_cnt - start);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    pulse_cnt = 0;
    mon_en    = 1'b0;
    keys      = '0;
    rst       = 1'b0;
    test_reset();
    test_idle_scan(20, "idle");
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_multi_row();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
